// File: rtl/th_second_pkg.sv
// =============================================================================
// Module  : th_pkg
// Brief   : Shared types and helpers for the th_second slot-fill stage.
// Revision: 1.0  initial release
// =============================================================================
`default_nettype none

package th_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_REQ  = 3'd2,
        S_DATA = 3'd3,
        S_UPD  = 3'd4
    } state_t;

    localparam int unsigned TH_ADDRESS = 10;
    localparam int unsigned TH_SLOTS   = 4;
    localparam int unsigned TH_WIDTH   = 32;
    localparam int unsigned TH_BURST   = 4;
    localparam int unsigned TH_QBITS   = 2;

    function automatic int unsigned th_log2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Fill length in words: packed code carries two ops per word.
    function automatic int unsigned th_len(input int unsigned burst, input logic pk);
        return pk ? burst / 2 : burst;
    endfunction

endpackage

`default_nettype wire

// File: rtl/th_second_if.sv
// =============================================================================
// Module  : th_second_if
// Brief   : Lookup/update port group between th_first (master) and th_second.
// Revision: 1.0  initial release
// =============================================================================
`default_nettype none

interface th_second_if #(
    parameter int unsigned ADDRESS = 10,
    parameter int unsigned SLOTS   = 4
);
    logic               is_lookup_i;
    logic               is_ack_o;
    logic [SLOTS-1:0]   is_l_addr_i;
    logic               is_packed_i;
    logic [ADDRESS-1:0] is_pc_i;
    logic               is_busy_o;
    logic               is_hit_i;
    logic               is_miss_i;
    logic               is_update_o;
    logic [SLOTS-1:0]   is_u_addr_o;
    logic               is_packed_o;

    modport slave (
        input  is_lookup_i, is_l_addr_i, is_packed_i, is_pc_i, is_hit_i, is_miss_i,
        output is_ack_o, is_busy_o, is_update_o, is_u_addr_o, is_packed_o
    );

    modport master (
        output is_lookup_i, is_l_addr_i, is_packed_i, is_pc_i, is_hit_i, is_miss_i,
        input  is_ack_o, is_busy_o, is_update_o, is_u_addr_o, is_packed_o
    );
endinterface

`default_nettype wire

// File: rtl/th_second_fifo.sv
// =============================================================================
// Module  : th_fifo
// Brief   : Parameterised synchronous FIFO with registered full/empty status.
// Revision: 1.0  initial release
// =============================================================================
`default_nettype none

module th_fifo #(
    parameter int unsigned DW    = 15,
    parameter int unsigned QBITS = 2
) (
    input  wire           clock_i,
    input  wire           reset_i,
    input  wire           push_i,
    input  wire           pop_i,
    input  wire  [DW-1:0] data_i,
    output logic [DW-1:0] data_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int unsigned DEPTH = 1 << QBITS;

    logic [DW-1:0]    mem_q [DEPTH];
    logic [QBITS-1:0] wr_q, wr_d;
    logic [QBITS-1:0] rd_q, rd_d;
    logic [QBITS:0]   cnt_q, cnt_d;
    logic             w_push, w_pop;

    assign full_o  = (cnt_q == (QBITS+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign w_pop   = pop_i & ~empty_o;
    assign w_push  = push_i & (~full_o | w_pop);
    assign data_o  = mem_q[rd_q];

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (w_push) wr_d = wr_q + QBITS'(1);
        if (w_pop)  rd_d = rd_q + QBITS'(1);
        case ({w_push, w_pop})
            2'b10:   cnt_d = cnt_q + (QBITS+1)'(1);
            2'b01:   cnt_d = cnt_q - (QBITS+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (w_push) mem_q[wr_q] <= data_i;
    end
endmodule

`default_nettype wire

// File: rtl/th_second.sv
// =============================================================================
// Module  : th_second
// Brief   : Queues slot lookups, bursts missed slots in from memory, reports refill.
//           TH_SECOND_WRAP_EN selects critical-word-first burst ordering.
// Revision: 1.0  initial release
// =============================================================================
`default_nettype none

module th_second
    import th_pkg::*;
#(
    parameter int unsigned ADDRESS = TH_ADDRESS,
    parameter int unsigned SLOTS   = TH_SLOTS,
    parameter int unsigned WIDTH   = TH_WIDTH,
    parameter int unsigned BURST   = TH_BURST,
    parameter int unsigned QBITS   = TH_QBITS
) (
    input  wire                               clock_i,
    input  wire                               reset_i,
    input  wire                               enable_i,
    th_second_if.slave                        is_bus,
    output logic                              mem_read_o,
    output logic [ADDRESS-1:0]                mem_addr_o,
    input  wire                               mem_ack_i,
    input  wire                               mem_ready_i,
    input  wire  [WIDTH-1:0]                  mem_data_i,
    output logic                              st_we_o,
    output logic [SLOTS+th_log2(BURST)-1:0]   st_addr_o,
    output logic [WIDTH-1:0]                  st_data_o
);
    localparam int unsigned WORD_W = th_log2(BURST);

    typedef struct packed {
        logic [ADDRESS-1:0] pc;
        logic [SLOTS-1:0]   slot;
        logic               pk;
    } entry_t;
    localparam int unsigned ENTRY_W = $bits(entry_t);

    entry_t             w_in, w_head;
    logic [ENTRY_W-1:0] w_head_raw;
    logic               w_full, w_empty, w_push, w_pop, w_ack;
    logic               w_update;
    logic [WORD_W-1:0]  w_len_m1, w_first;
    logic [ADDRESS-1:0] w_start;

    state_t             state_q, state_d;
    logic               miss_q, miss_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [WORD_W-1:0]  cnt_q, cnt_d;

    assign w_in  = '{pc: is_bus.is_pc_i, slot: is_bus.is_l_addr_i, pk: is_bus.is_packed_i};
    assign w_ack = is_bus.is_lookup_i & enable_i & ~w_full & ~reset_i;
    assign w_push = w_ack;

    th_fifo #(
        .DW    (ENTRY_W),
        .QBITS (QBITS)
    ) u_queue (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .data_i  (w_in),
        .data_o  (w_head_raw),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign w_head   = entry_t'(w_head_raw);
    assign w_len_m1 = w_head.pk ? WORD_W'(BURST/2 - 1) : WORD_W'(BURST - 1);

`ifdef TH_SECOND_WRAP_EN
    // Critical word first: memory wraps inside the aligned block for us.
    assign w_start = w_head.pc;
    assign w_first = w_head.pc[WORD_W-1:0] & w_len_m1;
`else
    assign w_start = w_head.pc & ~{{(ADDRESS-WORD_W){1'b0}}, w_len_m1};
    assign w_first = '0;
`endif

    always_comb begin
        state_d    = state_q;
        miss_d     = miss_q;
        word_d     = word_q;
        cnt_d      = cnt_q;
        w_pop      = 1'b0;
        w_update   = 1'b0;
        mem_read_o = 1'b0;
        mem_addr_o = '0;
        st_we_o    = 1'b0;
        st_addr_o  = '0;
        st_data_o  = '0;
        case (state_q)
            S_IDLE: if (!w_empty) state_d = S_WAIT;
            S_WAIT: begin
                // A miss seen while disabled is remembered until a fill may start.
                if (is_bus.is_miss_i || miss_q) begin
                    if (enable_i) begin
                        state_d = S_REQ;
                        miss_d  = 1'b0;
                    end else begin
                        miss_d  = 1'b1;
                    end
                end else if (is_bus.is_hit_i) begin
                    w_pop   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                mem_read_o = 1'b1;
                mem_addr_o = w_start;
                if (mem_ack_i) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    word_d  = w_first;
                end
            end
            S_DATA: begin
                if (mem_ready_i) begin
                    st_we_o   = 1'b1;
                    st_addr_o = {w_head.slot, word_q};
                    st_data_o = mem_data_i;
                    word_d    = (word_q + WORD_W'(1)) & w_len_m1;
                    cnt_d     = cnt_q + WORD_W'(1);
                    if (cnt_q == w_len_m1) state_d = S_UPD;
                end
            end
            S_UPD: begin
                w_update = 1'b1;
                w_pop    = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            miss_q  <= 1'b0;
            word_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            miss_q  <= miss_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
        end
    end

    assign is_bus.is_ack_o    = w_ack;
    assign is_bus.is_busy_o   = w_full;
    assign is_bus.is_update_o = w_update;
    assign is_bus.is_u_addr_o = w_update ? w_head.slot : '0;
    assign is_bus.is_packed_o = w_update & w_head.pk;
endmodule

`default_nettype wire

// File: tb/tb_th_second.sv
// =============================================================================
// Module  : tb_th_second
// Brief   : Self-checking bench for th_second (table vectors + random fills).
// Revision: 1.0  initial release
// =============================================================================
`default_nettype none

module tb_th_second;
    logic        clock_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        enable_i = 1'b1;
    logic        mem_read_o, mem_ack_i, mem_ready_i, st_we_o;
    logic [9:0]  mem_addr_o;
    logic [31:0] mem_data_i, st_data_o;
    logic [5:0]  st_addr_o;

    int checks = 0;
    int errors = 0;

    th_second_if #(.ADDRESS(10), .SLOTS(4)) ifc ();

    th_second dut (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .enable_i    (enable_i),
        .is_bus      (ifc),
        .mem_read_o  (mem_read_o),
        .mem_addr_o  (mem_addr_o),
        .mem_ack_i   (mem_ack_i),
        .mem_ready_i (mem_ready_i),
        .mem_data_i  (mem_data_i),
        .st_we_o     (st_we_o),
        .st_addr_o   (st_addr_o),
        .st_data_o   (st_data_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        logic [9:0] pc;
        logic [3:0] slot;
        bit         pk;
        int         verdict;   // 0 hit, 1 miss, 2 hit+miss, 3 miss while disabled
        logic [9:0] exp_addr;
        bit         drop_en;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    // Reference model
    function automatic int mlen(input bit pk);
        return pk ? 2 : 4;
    endfunction
    function automatic logic [9:0] mblk(input logic [9:0] a, input bit pk);
        return 10'(int'(a) - (int'(a) % mlen(pk)));
    endfunction
    function automatic logic [9:0] maddr(input logic [9:0] pc, input bit pk);
`ifdef TH_SECOND_WRAP_EN
        return pc;
`else
        return mblk(pc, pk);
`endif
    endfunction
    function automatic int mfirst(input logic [9:0] pc, input bit pk);
`ifdef TH_SECOND_WRAP_EN
        return int'(pc) % mlen(pk);
`else
        return 0;
`endif
    endfunction
    function automatic logic [31:0] mdata(input logic [9:0] a);
        return (32'(a) * 32'h9E3779B1) ^ 32'hA5A50000;
    endfunction

    task automatic do_lookup(input logic [9:0] pc, input logic [3:0] slot, input bit pk);
        bit ok;
        ok = 1'b0;
        ifc.is_pc_i     = pc;
        ifc.is_l_addr_i = slot;
        ifc.is_packed_i = pk;
        ifc.is_lookup_i = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            ok = ifc.is_ack_o;
            tick();
        end
        ifc.is_lookup_i = 1'b0;
        chk("lookup_ack", 32'(ok), 32'd1);
    endtask

    task automatic pulse(input bit hit, input bit miss);
        ifc.is_hit_i  = hit;
        ifc.is_miss_i = miss;
        tick();
        ifc.is_hit_i  = 1'b0;
        ifc.is_miss_i = 1'b0;
    endtask

    task automatic watch_no_read(input string name, input int n);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1;
            if (mem_read_o || st_we_o || ifc.is_update_o) seen = 1'b1;
            tick();
        end
        chk(name, 32'(seen), 32'd0);
    endtask

    // Serve one burst like a memory that wraps inside the aligned block.
    task automatic do_fill(input logic [9:0] pc, input logic [3:0] slot, input bit pk,
                           input logic [9:0] exp_addr, input bit drop_en);
        int len, first, w;
        bit seen;
        logic [9:0] a0, blk0, eblk;
        len   = mlen(pk);
        first = mfirst(pc, pk);
        eblk  = mblk(pc, pk);
        seen  = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            #1;
            seen = mem_read_o;
            if (!seen) tick();
        end
        chk("mem_read", 32'(seen), 32'd1);
        if (!seen) return;
        chk("mem_addr", 32'(mem_addr_o), 32'(exp_addr));
        a0   = mem_addr_o;
        blk0 = mblk(a0, pk);
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        for (int k = 0; k < len; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            w = (first + k) % len;
            mem_ready_i = 1'b1;
            mem_data_i  = mdata(10'(int'(blk0) + ((int'(a0) - int'(blk0) + k) % len)));
            #1;
            chk("st_we", 32'(st_we_o), 32'd1);
            chk("st_addr", 32'(st_addr_o), 32'({slot, 2'(w)}));
            chk("st_data", st_data_o, mdata(10'(int'(eblk) + w)));
            if (drop_en && k == 1) enable_i = 1'b0;
            tick();
            mem_ready_i = 1'b0;
            mem_data_i  = 32'($urandom);
        end
        #1;
        chk("update", 32'(ifc.is_update_o), 32'd1);
        chk("u_addr", 32'(ifc.is_u_addr_o), 32'(slot));
        chk("u_packed", 32'(ifc.is_packed_o), 32'(pk));
        tick();
        chk("update_pulse", 32'(ifc.is_update_o), 32'd0);
        enable_i = 1'b1;
    endtask

    task automatic run_txn(input vec_t v);
        do_lookup(v.pc, v.slot, v.pk);
        repeat (3) tick();
        case (v.verdict)
            0: begin
                pulse(1'b1, 1'b0);
                watch_no_read("hit_no_read", 5);
                chk("hit_popped", 32'(ifc.is_busy_o), 32'd0);
            end
            3: begin
                enable_i = 1'b0;
                pulse(1'b0, 1'b1);
                watch_no_read("held_miss_no_read", 4);
                enable_i = 1'b1;
                do_fill(v.pc, v.slot, v.pk, v.exp_addr, v.drop_en);
            end
            default: begin
                pulse(v.verdict == 2, 1'b1);
                do_fill(v.pc, v.slot, v.pk, v.exp_addr, v.drop_en);
            end
        endcase
        repeat (2) tick();
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_mem_read"}, 32'(mem_read_o), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr_o), 32'd0);
        chk({tag, "_st_we"}, 32'(st_we_o), 32'd0);
        chk({tag, "_st_addr"}, 32'(st_addr_o), 32'd0);
        chk({tag, "_st_data"}, st_data_o, 32'd0);
        chk({tag, "_update"}, 32'(ifc.is_update_o), 32'd0);
        chk({tag, "_u_addr"}, 32'(ifc.is_u_addr_o), 32'd0);
        chk({tag, "_packed"}, 32'(ifc.is_packed_o), 32'd0);
        chk({tag, "_busy"}, 32'(ifc.is_busy_o), 32'd0);
    endtask

    initial begin
        vec_t rv;
        ifc.is_lookup_i = 1'b0; ifc.is_l_addr_i = '0; ifc.is_packed_i = 1'b0;
        ifc.is_pc_i = '0; ifc.is_hit_i = 1'b0; ifc.is_miss_i = 1'b0;
        mem_ack_i = 1'b0; mem_ready_i = 1'b0; mem_data_i = '0;

`ifdef TH_SECOND_WRAP_EN
        vecs[0] = '{pc: 10'd16,   slot: 4'd1,  pk: 1'b0, verdict: 1, exp_addr: 10'd16,   drop_en: 1'b0};
        vecs[1] = '{pc: 10'd16,   slot: 4'd1,  pk: 1'b0, verdict: 0, exp_addr: 10'd16,   drop_en: 1'b0};
        vecs[2] = '{pc: 10'd34,   slot: 4'd2,  pk: 1'b1, verdict: 1, exp_addr: 10'd34,   drop_en: 1'b0};
        vecs[3] = '{pc: 10'd18,   slot: 4'd3,  pk: 1'b0, verdict: 2, exp_addr: 10'd18,   drop_en: 1'b1};
        vecs[4] = '{pc: 10'd1023, slot: 4'd15, pk: 1'b1, verdict: 1, exp_addr: 10'd1023, drop_en: 1'b0};
        vecs[5] = '{pc: 10'd7,    slot: 4'd0,  pk: 1'b0, verdict: 3, exp_addr: 10'd7,    drop_en: 1'b0};
`else
        vecs[0] = '{pc: 10'd16,   slot: 4'd1,  pk: 1'b0, verdict: 1, exp_addr: 10'd16,   drop_en: 1'b0};
        vecs[1] = '{pc: 10'd16,   slot: 4'd1,  pk: 1'b0, verdict: 0, exp_addr: 10'd16,   drop_en: 1'b0};
        vecs[2] = '{pc: 10'd34,   slot: 4'd2,  pk: 1'b1, verdict: 1, exp_addr: 10'd34,   drop_en: 1'b0};
        vecs[3] = '{pc: 10'd18,   slot: 4'd3,  pk: 1'b0, verdict: 2, exp_addr: 10'd16,   drop_en: 1'b1};
        vecs[4] = '{pc: 10'd1023, slot: 4'd15, pk: 1'b1, verdict: 1, exp_addr: 10'd1022, drop_en: 1'b0};
        vecs[5] = '{pc: 10'd7,    slot: 4'd0,  pk: 1'b0, verdict: 3, exp_addr: 10'd4,    drop_en: 1'b0};
`endif

        // Power-on reset with a lookup pending
        ifc.is_lookup_i = 1'b1;
        tick();
        chk("ack_in_reset", 32'(ifc.is_ack_o), 32'd0);
        tick();
        ifc.is_lookup_i = 1'b0;
        reset_i = 1'b0;
        #1;
        chk_idle_outputs("por");
        tick();

        // Reset in the middle of a burst
        do_lookup(10'd40, 4'd5, 1'b0);
        repeat (3) tick();
        pulse(1'b0, 1'b1);
        for (int i = 0; i < 10 && !mem_read_o; i++) tick();
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        repeat (2) begin
            mem_ready_i = 1'b1;
            mem_data_i  = 32'hDEAD_BEEF;
            tick();
        end
        reset_i = 1'b1;
        ifc.is_lookup_i = 1'b1;
        #1;
        chk("ack_mid_reset", 32'(ifc.is_ack_o), 32'd0);
        repeat (2) tick();
        reset_i = 1'b0;
        ifc.is_lookup_i = 1'b0;
        #1;
        chk_idle_outputs("rst");
        watch_no_read("after_reset_quiet", 3);
        mem_ready_i = 1'b0;
        pulse(1'b0, 1'b1);
        watch_no_read("empty_verdict_ignored", 5);

        // Directed vectors
        for (int i = 0; i < 6; i++) run_txn(vecs[i]);

        // Fill the queue: the fifth lookup is refused until a hit drains one
        for (int i = 0; i < 4; i++) do_lookup(10'(100 + i), 4'(4 + i), 1'b0);
        ifc.is_lookup_i = 1'b1;
        #1;
        chk("full_ack", 32'(ifc.is_ack_o), 32'd0);
        chk("full_busy", 32'(ifc.is_busy_o), 32'd1);
        pulse(1'b1, 1'b0);
        #1;
        chk("drain_ack", 32'(ifc.is_ack_o), 32'd1);
        chk("drain_busy", 32'(ifc.is_busy_o), 32'd0);
        tick();
        ifc.is_lookup_i = 1'b0;
        chk("refill_busy", 32'(ifc.is_busy_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
            repeat (3) tick();
            pulse(1'b1, 1'b0);
        end
        repeat (2) tick();
        chk("queue_empty_busy", 32'(ifc.is_busy_o), 32'd0);
        pulse(1'b0, 1'b1);
        watch_no_read("queue_empty_quiet", 5);

        // Randomized transactions against the model
        for (int i = 0; i < 30; i++) begin
            rv.pc       = 10'($urandom);
            rv.slot     = 4'($urandom);
            rv.pk       = 1'($urandom);
            rv.verdict  = int'($urandom_range(0, 3));
            rv.exp_addr = maddr(rv.pc, rv.pk);
            rv.drop_en  = 1'($urandom);
            run_txn(rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, limit %0d ns", 2000000);
        $fatal(1);
    end
endmodule

`default_nettype wire
